led_bank_arbiter: RTL and testbench

Shares the board's 10-LED bank among three display sources: error flash, ALU result, and idle sweep animation. It grants the bank by fixed priority, enforces a minimum on-screen hold time measured in prescaled ticks, and drives the registered `lights` bus. It sits between the pattern/result generators and the LED pins, and also supplies the shared slow tick that those generators step on.

---
 rtl/led_bank_arbiter.sv | 167 ++++++++++++++++
 tb/tb_led_bank_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: shares a 10-LED bank among three sources (0 = highest
// priority). A granted owner keeps the bank for at least HOLD_TICKS prescaled
// ticks. After that a higher-priority request takes the bank through a short
// SWITCH state. The module also supplies the shared slow tick.
//
// Optional feature: define LED_BANK_ARB_GAP_EN to blank the bank during
// SWITCH and to delay the new grant until the next tick.
module led_bank_arbiter #(
  parameter int TICK_DIV   = 650000,
  parameter int HOLD_TICKS = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic [9:0] data0,
  input  logic [9:0] data1,
  input  logic [9:0] data2,
  output logic [2:0] gnt,
  output logic [9:0] lights,
  output logic       tick,
  output logic       busy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {IDLE, HOLD, OPEN, SWITCH} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   presc;
  logic [HW-1:0]   hold, hold_n;
  logic [2:0]      owner, owner_n;   // one-hot index of the current owner
  logic [2:0]      gnt_n;
  logic [9:0]      lights_n;
  logic            busy_n;

  logic [2:0]      pick;             // lowest-index requester, one-hot
  logic            owner_req;
  logic [9:0]      owner_data;
  logic            higher_req;
  logic            switch_go;

  assign pick       = req & (~req + 3'b001);
  assign owner_req  = |(req & owner);
  assign owner_data = ({10{owner[0]}} & data0) |
                      ({10{owner[1]}} & data1) |
                      ({10{owner[2]}} & data2);
  // For a one-hot owner, owner - 1 masks exactly the higher-priority bits.
  assign higher_req = |(req & (owner - 3'b001));

`ifdef LED_BANK_ARB_GAP_EN
  assign switch_go = tick;
`else
  assign switch_go = 1'b1;
`endif

  // Free-running prescaler; tick is registered so it is high while presc is at its top value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      tick  <= (presc == PW'(TICK_DIV - 2));
      presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
    end
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      hold   <= '0;
      owner  <= '0;
      gnt    <= '0;
      lights <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      hold   <= hold_n;
      owner  <= owner_n;
      gnt    <= gnt_n;
      lights <= lights_n;
      busy   <= busy_n;
    end
  end

  // Next-state, grant and LED pattern selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n  = state;
    hold_n   = hold;
    owner_n  = owner;
    gnt_n    = '0;
    lights_n = lights;

    unique case (state)
      IDLE: begin
        lights_n = '0;
        if (|req) begin
          owner_n = pick;
          gnt_n   = pick;
          hold_n  = HW'(HOLD_TICKS);
          state_n = HOLD;
        end
      end

      HOLD: begin
        // If the owner lets go, the grant drops and the bank freezes until the hold expires.
        if (owner_req) begin
          gnt_n    = owner;
          lights_n = owner_data;
        end
        if (tick && hold != '0) begin
          hold_n = hold - HW'(1);
          if (hold == HW'(1)) begin
            if (owner_req) begin
              state_n = OPEN;
            end else begin
              state_n  = IDLE;
              gnt_n    = '0;
              lights_n = '0;
            end
          end
        end
      end

      OPEN: begin
        // A higher request wins even if the owner drops in the same cycle.
        if (higher_req) begin
          state_n = SWITCH;
`ifdef LED_BANK_ARB_GAP_EN
          lights_n = '0;
`endif
        end else if (!owner_req) begin
          state_n  = IDLE;
          lights_n = '0;
        end else begin
          gnt_n    = owner;
          lights_n = owner_data;
        end
      end

      SWITCH: begin
`ifdef LED_BANK_ARB_GAP_EN
        lights_n = '0;
`endif
        if (switch_go) begin
          if (|req) begin
            owner_n = pick;
            gnt_n   = pick;
            hold_n  = HW'(HOLD_TICKS);
            state_n = HOLD;
          end else begin
            state_n  = IDLE;
            lights_n = '0;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed testbench for led_bank_arbiter with TICK_DIV=4 and HOLD_TICKS=2.
// Each test starts from a fresh reset, so the tick phase is known. After the
// release, tick is high following edges 3, 7, 11 and so on.
module tb_led_bank_arbiter;

  logic       clock;
  logic       resetn;
  logic [2:0] req;
  logic [9:0] data0, data1, data2;
  logic [2:0] gnt;
  logic [9:0] lights;
  logic       tick;
  logic       busy;
  logic [13:0] obs;

  int checks = 0;
  int fails  = 0;

  assign obs = {gnt, lights, busy};

  led_bank_arbiter #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .clock  (clock),
    .resetn (resetn),
    .req    (req),
    .data0  (data0),
    .data1  (data1),
    .data2  (data2),
    .gnt    (gnt),
    .lights (lights),
    .tick   (tick),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance n edges and sample 1 time unit after each one. Every edge also checks that gnt is never multi-hot.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if ($countones(gnt) > 1) begin
        fails++;
        $display("FAIL gnt_onehot: got gnt=%b want at most one bit set", gnt);
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req    = 3'b000;
    data0  = '0;
    data1  = '0;
    data2  = '0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    req   = 3'b001;
    data0 = 10'h3FF;
    step(2);
    checks++;
    if (obs !== {3'b001, 10'h3FF, 1'b1}) begin
      fails++;
      $display("FAIL reset_pre: got gnt=%b lights=%h busy=%b want 001/3ff/1", gnt, lights, busy);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({obs, tick} !== 15'h0) begin
      fails++;
      $display("FAIL reset_async: got gnt=%b lights=%h busy=%b tick=%b want all 0", gnt, lights, busy, tick);
    end
    req = 3'b000;
    #1 resetn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      checks++;
      if ({obs, tick} !== {14'h0, (k % 4 == 3)}) begin
        fails++;
        $display("FAIL reset_tick edge %0d: got gnt=%b lights=%h busy=%b tick=%b want 000/000/0 tick=%b",
                 k, gnt, lights, busy, tick, (k % 4 == 3));
      end
    end
  endtask

  task automatic test_single_grant();
    do_reset();
    req   = 3'b100;
    data2 = 10'h2AA;
    step(1);
    checks++;
    if (obs !== {3'b100, 10'h000, 1'b1}) begin
      fails++;
      $display("FAIL single_gnt: got gnt=%b lights=%h busy=%b want 100/000/1", gnt, lights, busy);
    end
    step(1);
    checks++;
    if (obs !== {3'b100, 10'h2AA, 1'b1}) begin
      fails++;
      $display("FAIL single_lights: got gnt=%b lights=%h busy=%b want 100/2aa/1", gnt, lights, busy);
    end
    data2 = 10'h155;
    step(1);
    checks++;
    if (obs !== {3'b100, 10'h155, 1'b1}) begin
      fails++;
      $display("FAIL single_data_follow: got gnt=%b lights=%h busy=%b want 100/155/1", gnt, lights, busy);
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req   = 3'b100;
    data2 = 10'h2AA;
    data0 = 10'h155;
    step(1);
    req = 3'b101;
    step(6);  // edge 7: one tick consumed, still HOLD
    checks++;
    if (obs !== {3'b100, 10'h2AA, 1'b1}) begin
      fails++;
      $display("FAIL preempt_hold: got gnt=%b lights=%h busy=%b want 100/2aa/1", gnt, lights, busy);
    end
    step(1);  // edge 8: second tick, now OPEN
    checks++;
    if (obs !== {3'b100, 10'h2AA, 1'b1}) begin
      fails++;
      $display("FAIL preempt_open: got gnt=%b lights=%h busy=%b want 100/2aa/1", gnt, lights, busy);
    end
    step(1);  // edge 9: SWITCH
`ifdef LED_BANK_ARB_GAP_EN
    checks++;
    if (obs !== {3'b000, 10'h000, 1'b1}) begin
      fails++;
      $display("FAIL preempt_switch: got gnt=%b lights=%h busy=%b want 000/000/1", gnt, lights, busy);
    end
    step(2);  // edge 11: still waiting for tick
    checks++;
    if (obs !== {3'b000, 10'h000, 1'b1}) begin
      fails++;
      $display("FAIL preempt_gap_wait: got gnt=%b lights=%h busy=%b want 000/000/1", gnt, lights, busy);
    end
    step(1);  // edge 12: tick seen, grant source 0
    checks++;
    if (obs !== {3'b001, 10'h000, 1'b1}) begin
      fails++;
      $display("FAIL preempt_new_gnt: got gnt=%b lights=%h busy=%b want 001/000/1", gnt, lights, busy);
    end
`else
    checks++;
    if (obs !== {3'b000, 10'h2AA, 1'b1}) begin
      fails++;
      $display("FAIL preempt_switch: got gnt=%b lights=%h busy=%b want 000/2aa/1", gnt, lights, busy);
    end
    step(1);  // edge 10: grant source 0
    checks++;
    if (obs !== {3'b001, 10'h2AA, 1'b1}) begin
      fails++;
      $display("FAIL preempt_new_gnt: got gnt=%b lights=%h busy=%b want 001/2aa/1", gnt, lights, busy);
    end
`endif
    step(1);
    checks++;
    if (obs !== {3'b001, 10'h155, 1'b1}) begin
      fails++;
      $display("FAIL preempt_new_data: got gnt=%b lights=%h busy=%b want 001/155/1", gnt, lights, busy);
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    req   = 3'b010;
    data1 = 10'h00F;
    step(2);
    req = 3'b000;
    step(1);  // edge 3
    checks++;
    if (obs !== {3'b000, 10'h00F, 1'b1}) begin
      fails++;
      $display("FAIL drop_freeze: got gnt=%b lights=%h busy=%b want 000/00f/1", gnt, lights, busy);
    end
    step(4);  // edge 7
    checks++;
    if (obs !== {3'b000, 10'h00F, 1'b1}) begin
      fails++;
      $display("FAIL drop_still_hold: got gnt=%b lights=%h busy=%b want 000/00f/1", gnt, lights, busy);
    end
    step(1);  // edge 8: hold expires into IDLE
    checks++;
    if (obs !== {3'b000, 10'h000, 1'b0}) begin
      fails++;
      $display("FAIL drop_idle: got gnt=%b lights=%h busy=%b want 000/000/0", gnt, lights, busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req   = 3'b111;
    data0 = 10'h155;
    data1 = 10'h0F0;
    data2 = 10'h2AA;
    step(1);
    checks++;
    if (obs !== {3'b001, 10'h000, 1'b1}) begin
      fails++;
      $display("FAIL simul_gnt: got gnt=%b lights=%h busy=%b want 001/000/1", gnt, lights, busy);
    end
    step(9);  // edge 10: in OPEN with lower requests pending
    checks++;
    if (obs !== {3'b001, 10'h155, 1'b1}) begin
      fails++;
      $display("FAIL simul_open_keep: got gnt=%b lights=%h busy=%b want 001/155/1", gnt, lights, busy);
    end
    req = 3'b110;
    step(1);  // edge 11: owner dropped, no higher request, so IDLE
    checks++;
    if (obs !== {3'b000, 10'h000, 1'b0}) begin
      fails++;
      $display("FAIL simul_open_idle: got gnt=%b lights=%h busy=%b want 000/000/0", gnt, lights, busy);
    end
    step(1);
    checks++;
    if (obs !== {3'b010, 10'h000, 1'b1}) begin
      fails++;
      $display("FAIL simul_regrant: got gnt=%b lights=%h busy=%b want 010/000/1", gnt, lights, busy);
    end
  endtask

  task automatic test_drop_and_preempt();
    do_reset();
    req   = 3'b010;
    data1 = 10'h0F0;
    data0 = 10'h155;
    step(8);  // edge 8: OPEN
    req = 3'b001;
    step(1);  // edge 9: higher wins, so SWITCH rather than IDLE
`ifdef LED_BANK_ARB_GAP_EN
    checks++;
    if (obs !== {3'b000, 10'h000, 1'b1}) begin
      fails++;
      $display("FAIL dp_switch: got gnt=%b lights=%h busy=%b want 000/000/1", gnt, lights, busy);
    end
    step(3);
`else
    checks++;
    if (obs !== {3'b000, 10'h0F0, 1'b1}) begin
      fails++;
      $display("FAIL dp_switch: got gnt=%b lights=%h busy=%b want 000/0f0/1", gnt, lights, busy);
    end
    step(1);
`endif
    checks++;
    if (gnt !== 3'b001) begin
      fails++;
      $display("FAIL dp_new_gnt: got gnt=%b want 001", gnt);
    end
  endtask

  initial begin
    resetn = 1'b0;
    req    = 3'b000;
    data0  = '0;
    data1  = '0;
    data2  = '0;
    test_reset();
    test_single_grant();
    test_no_preempt();
    test_owner_drop();
    test_simultaneous();
    test_drop_and_preempt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
